// File: rtl/muldiv_issue_pkg.sv
// Shared definitions for the M-extension issue/writeback controller:
// widths, funct3 codes and FSM state encodings.
package muldiv_issue_pkg;

  localparam int XLEN   = 32;
  localparam int REGA_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // All multiply variants have funct3[2] clear.
  function automatic logic is_mul_op(input logic [2:0] f3);
    return (f3[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_issue_md_special.sv
// Zero-operand detection and special-result selection for the mul/div issue path.
// MD_FASTPATH_EN enables the trivial-operand bypass; otherwise fast_hit_o stays low.
module md_special
  import muldiv_issue_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] result_i,
  output logic            fast_hit_o,
  output logic [XLEN-1:0] fast_data_o,
  output logic [XLEN-1:0] wb_data_o
);

  logic b_zero_s;

  assign b_zero_s = (b_i == {XLEN{1'b0}});

  // Result of an op whose outcome is fixed by a zero operand.
  always_comb begin
    fast_data_o = {XLEN{1'b0}};
    case (funct3_i)
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: fast_data_o = {XLEN{1'b0}};
      F3_DIV, F3_DIVU:                      fast_data_o = {XLEN{1'b1}};
      F3_REM, F3_REMU:                      fast_data_o = a_i;
      default:                              fast_data_o = {XLEN{1'b0}};
    endcase
  end

  // Signed divide by zero must give all ones whatever sign the dividend has.
  always_comb begin
    wb_data_o = result_i;
    if ((funct3_i == F3_DIV) && b_zero_s) begin
      wb_data_o = {XLEN{1'b1}};
    end else begin
      wb_data_o = result_i;
    end
  end

`ifdef MD_FASTPATH_EN
  logic a_zero_s;
  assign a_zero_s   = (a_i == {XLEN{1'b0}});
  assign fast_hit_o = b_zero_s || (a_zero_s && is_mul_op(funct3_i));
`else
  assign fast_hit_o = 1'b0;
`endif

endmodule

// File: rtl/muldiv_issue.sv
// EX-stage issue/writeback controller between the pipeline and the mul/div unit.
// Optional MD_FASTPATH_EN retires zero-operand ops without starting the unit.
module muldiv_issue
  import muldiv_issue_pkg::*;
(
  input  logic              i_clk_n,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [REGA_W-1:0] i_rd,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [REGA_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [XLEN-1:0]   o_md_a,
  output logic [XLEN-1:0]   o_md_b,
  output logic [2:0]        o_md_funct3,
  output logic              o_md_en,
  input  logic [XLEN-1:0]   i_md_result,
  input  logic              i_md_busy
);

  logic [1:0]        state_q,   state_d;
  logic [XLEN-1:0]   md_a_q,    md_a_d;
  logic [XLEN-1:0]   md_b_q,    md_b_d;
  logic [2:0]        md_f3_q,   md_f3_d;
  logic [REGA_W-1:0] rd_q,      rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic              accept_s;
  logic              in_idle_s;
  logic [2:0]        sp_f3_s;
  logic [XLEN-1:0]   sp_a_s;
  logic [XLEN-1:0]   sp_b_s;
  logic              sp_fast_hit_s;
  logic [XLEN-1:0]   sp_fast_data_s;
  logic [XLEN-1:0]   sp_wb_data_s;

  // A busy unit in IDLE is an orphan from a flushed op; wait for it to drain.
  assign in_idle_s = (state_q == S_IDLE);
  assign accept_s  = in_idle_s && i_valid && !i_flush && !i_md_busy;

  // Fast-path decode looks at the incoming operands, the fix-up at the latched ones.
  assign sp_f3_s = in_idle_s ? i_funct3 : md_f3_q;
  assign sp_a_s  = in_idle_s ? i_rs1    : md_a_q;
  assign sp_b_s  = in_idle_s ? i_rs2    : md_b_q;

  md_special u_special (
    .funct3_i    (sp_f3_s),
    .a_i         (sp_a_s),
    .b_i         (sp_b_s),
    .result_i    (i_md_result),
    .fast_hit_o  (sp_fast_hit_s),
    .fast_data_o (sp_fast_data_s),
    .wb_data_o   (sp_wb_data_s)
  );

  // Next-state, operand latch and writeback capture.
  always_comb begin
    state_d   = state_q;
    md_a_d    = md_a_q;
    md_b_d    = md_b_q;
    md_f3_d   = md_f3_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          md_a_d  = i_rs1;
          md_b_d  = i_rs2;
          md_f3_d = i_funct3;
          rd_d    = i_rd;
          if (sp_fast_hit_s) begin
            state_d   = S_DONE;
            wb_data_d = sp_fast_data_s;
          end else begin
            state_d   = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (!i_md_busy) begin
          state_d   = S_DONE;
          wb_data_d = sp_wb_data_s;
        end else begin
          state_d = S_WAIT;
        end
      end
      // The instruction is already retiring, so a flush here is ignored.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      md_a_q    <= {XLEN{1'b0}};
      md_b_q    <= {XLEN{1'b0}};
      md_f3_q   <= 3'b000;
      rd_q      <= {REGA_W{1'b0}};
      wb_data_q <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      md_a_q    <= md_a_d;
      md_b_q    <= md_b_d;
      md_f3_q   <= md_f3_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // The pipeline is released in DONE so it advances on the retiring edge.
  always_comb begin
    o_stall = 1'b0;
    case (state_q)
      S_IDLE:  o_stall = i_valid;
      S_ISSUE: o_stall = 1'b1;
      S_WAIT:  o_stall = 1'b1;
      S_DONE:  o_stall = 1'b0;
      default: o_stall = 1'b0;
    endcase
  end

  assign o_md_en     = (state_q == S_ISSUE);
  assign o_wb_valid  = (state_q == S_DONE);
  assign o_wb_rd     = rd_q;
  assign o_wb_data   = wb_data_q;
  assign o_md_a      = md_a_q;
  assign o_md_b      = md_b_q;
  assign o_md_funct3 = md_f3_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: a behavioural mul/div unit plus an arithmetic reference
// for results and stall counts; honours MD_FASTPATH_EN when it is defined.
module tb_muldiv_issue;
  import muldiv_issue_pkg::*;

  logic        i_clk_n = 1'b0;
  logic        i_rst, i_valid, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2;
  logic [4:0]  i_rd;
  logic        o_stall, o_wb_valid, o_md_en;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_md_a, o_md_b;
  logic [2:0]  o_md_funct3;
  logic [31:0] md_result;
  logic        md_busy;
  int          unit_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  muldiv_issue dut (
    .i_clk_n(i_clk_n), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .o_stall(o_stall), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_md_a(o_md_a), .o_md_b(o_md_b), .o_md_funct3(o_md_funct3), .o_md_en(o_md_en),
    .i_md_result(md_result), .i_md_busy(md_busy)
  );

  always #5 i_clk_n = ~i_clk_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Unit busy length: multiplier iterates over |B|, divider always 32 steps.
  function automatic int busy_len(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] mag;
    if (f3[2]) return 32;
    mag = (f3 != F3_MULHU && b[31]) ? (32'd0 - b) : b;
    return bitlen(mag);
  endfunction

  // Architectural M-extension result.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      F3_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      F3_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural unit; its signed divide-by-zero gives +1 for negative dividends.
  always @(posedge i_clk_n) begin
    if (i_rst) unit_cnt <= 0;
    else if (o_md_en) unit_cnt <= busy_len(o_md_funct3, o_md_b);
    else if (unit_cnt > 0) unit_cnt <= unit_cnt - 1;
  end
  assign md_busy = (unit_cnt != 0);
  always_comb begin
    md_result = ref_result(o_md_funct3, o_md_a, o_md_b);
    if (o_md_funct3 == F3_DIV && o_md_b == 32'd0 && o_md_a[31]) md_result = 32'd1;
  end

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_FASTPATH_EN
    return (b == 32'd0) || (a == 32'd0 && f3[2] == 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  // Present one op at a negedge and follow it to writeback; extra = orphan drain cycles.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int extra);
    int stalls = 0;
    int ens = 0;
    bit seen_wb = 1'b0;
    bit hold_bad = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [4:0] wrd = 5'd0;
    bit fast;
    int exp_stall;
    fast = is_fast(f3, a, b);
    exp_stall = (fast ? 1 : 3 + busy_len(f3, b)) + extra;
    i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    for (int c = 0; c < 200 && !seen_wb; c++) begin
      #1;
      if (o_stall) stalls++;
      if (o_md_en) begin
        ens++;
        check_eq({tag, "_en_busy"}, 32'(md_busy), 32'd0);
      end
      if ((ens > 0 || o_wb_valid) && (o_md_a !== a || o_md_b !== b || o_md_funct3 !== f3)) hold_bad = 1'b1;
      if (o_wb_valid) begin
        seen_wb = 1'b1; wdata = o_wb_data; wrd = o_wb_rd;
      end
      @(posedge i_clk_n);
      @(negedge i_clk_n);
    end
    i_valid = 1'b0;
    check_eq({tag, "_wb_seen"}, 32'(seen_wb), 32'd1);
    check_eq({tag, "_data"}, wdata, ref_result(f3, a, b));
    check_eq({tag, "_rd"}, 32'(wrd), 32'(rd));
    check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
    check_eq({tag, "_en_count"}, 32'(ens), fast ? 32'd0 : 32'd1);
    check_eq({tag, "_op_hold"}, 32'(hold_bad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {20'd0, o_stall, o_md_en, o_wb_valid, o_wb_rd, o_md_funct3}, 32'd0);
    check_eq({tag, "_md_a"}, o_md_a, 32'd0);
    check_eq({tag, "_md_b"}, o_md_b, 32'd0);
    check_eq({tag, "_wb_data"}, o_wb_data, 32'd0);
  endtask

  initial begin
    int wb_seen;
    logic [2:0] f3;
    logic [31:0] a, b;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    i_funct3 = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_rd = 5'd0;
    repeat (2) @(negedge i_clk_n);
    #1;
    check_reset_outputs("reset");
    i_rst = 1'b0;
    @(negedge i_clk_n);

    run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 5'd5, 0);
    run_op("div_m20_3", F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 0);
    run_op("rem_m20_3", F3_REM, 32'hFFFF_FFEC, 32'd3, 5'd8, 0);
    run_op("div_by0", F3_DIV, 32'hFFFF_FFF0, 32'd0, 5'd10, 0);
    run_op("remu_by0", F3_REMU, 32'd9, 32'd0, 5'd11, 0);
    run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    run_op("mul_a0", F3_MUL, 32'd0, 32'd12345, 5'd14, 0);

    // Valid together with flush must not be accepted.
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = F3_MUL; i_rs1 = 32'd3; i_rs2 = 32'd3; i_rd = 5'd1;
    @(posedge i_clk_n);
    @(negedge i_clk_n);
    i_valid = 1'b0; i_flush = 1'b0;
    #1;
    check_eq("flush_accept_idle", {30'd0, o_stall, o_md_en}, 32'd0);
    @(negedge i_clk_n);

    // DIVU flushed in its tenth WAIT cycle, then a MUL waits for the orphan to drain.
    i_valid = 1'b1; i_funct3 = F3_DIVU; i_rs1 = 32'd1000; i_rs2 = 32'd7; i_rd = 5'd9;
    wb_seen = 0;
    for (int c = 0; c < 11; c++) begin
      #1;
      if (o_wb_valid) wb_seen++;
      @(posedge i_clk_n);
      @(negedge i_clk_n);
    end
    i_flush = 1'b1;
    #1;
    if (o_wb_valid) wb_seen++;
    check_eq("flush_wait_stall", 32'(o_stall), 32'd1);
    @(posedge i_clk_n);
    @(negedge i_clk_n);
    i_flush = 1'b0;
    check_eq("flush_no_wb", 32'(wb_seen), 32'd0);
    run_op("mul_after_flush", F3_MUL, 32'd2, 32'd3, 5'd4, 22);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom();
        default: b = 32'($urandom_range(1, 300));
      endcase
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        default: a = $urandom();
      endcase
      run_op($sformatf("rand%0d", i), f3, a, b, 5'($urandom_range(0, 31)), 0);
    end

    // Reset in the middle of a divide, then a fresh MUL.
    i_valid = 1'b1; i_funct3 = F3_DIV; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd = 5'd6;
    repeat (8) @(negedge i_clk_n);
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk_n);
    @(negedge i_clk_n);
    #1;
    check_reset_outputs("rst_mid");
    i_rst = 1'b0;
    run_op("mul_1x1", F3_MUL, 32'd1, 32'd1, 5'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
